rob_multi: RTL and testbench

- Parametrised in-order results buffer for the out-of-order core; successor to the single-port, fixed-16-entry results buffer.
- Allocates entries in program order and accepts WB_PORTS execution writebacks per cycle.
- Forwards each writeback to the PRF and commits up to RET_W entries per cycle from the head.
- Handles branch redirect with flush of younger entries, and sticky halt.

---
 rtl/rob_multi_if.sv | 46 ++++
 rtl/rob_multi.sv | 229 ++++++++++++++++++++++
 tb/tb_rob_multi.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_if.sv
// Results-buffer port bundle: dispatch allocation, execution writebacks, PRF writes, commit and redirect.
// master = dispatch/execute side, slave = the results buffer.
interface rob_multi_if #(
    parameter int DEPTH    = 16,
    parameter int IDW      = $clog2(DEPTH),
    parameter int DATA_W   = 8,
    parameter int PREG_W   = 4,
    parameter int AREG_W   = 4,
    parameter int WB_PORTS = 2,
    parameter int RET_W    = 2
);
    logic                         alloc_valid;
    logic                         alloc_ready;
    logic [IDW-1:0]               alloc_id;
    logic [WB_PORTS-1:0]          wb_valid;
    logic [WB_PORTS*IDW-1:0]      wb_id;
    logic [WB_PORTS*8-1:0]        wb_flags;
    logic [WB_PORTS*DATA_W-1:0]   wb_value;
    logic [WB_PORTS*PREG_W-1:0]   wb_preg;
    logic [WB_PORTS*AREG_W-1:0]   wb_areg;
    logic [WB_PORTS-1:0]          prf_valid;
    logic [WB_PORTS*PREG_W-1:0]   prf_id;
    logic [WB_PORTS*DATA_W-1:0]   prf_value;
    logic [RET_W-1:0]             retire_valid;
    logic [RET_W*AREG_W-1:0]      retire_areg;
    logic [RET_W*PREG_W-1:0]      retire_preg;
    logic                         branch_valid;
    logic                         branch_not_taken;
    logic [DATA_W-1:0]            new_pc;
    logic                         halted;
    logic [IDW:0]                 count;

    modport master (
        output alloc_valid, wb_valid, wb_id, wb_flags, wb_value, wb_preg, wb_areg,
        input  alloc_ready, alloc_id, prf_valid, prf_id, prf_value,
               retire_valid, retire_areg, retire_preg,
               branch_valid, branch_not_taken, new_pc, halted, count
    );

    modport slave (
        input  alloc_valid, wb_valid, wb_id, wb_flags, wb_value, wb_preg, wb_areg,
        output alloc_ready, alloc_id, prf_valid, prf_id, prf_value,
               retire_valid, retire_areg, retire_preg,
               branch_valid, branch_not_taken, new_pc, halted, count
    );
endinterface

// File: rtl/rob_multi.sv
// In-order results buffer: program-order alloc, WB_PORTS writebacks, up to RET_W commits/cycle; PRF/retire/redirect outputs 1 cycle after the event.
// Backpressure: alloc_ready drops when full or halted; writebacks are never stalled (invalid targets are dropped).
module rob_multi #(
    parameter int DEPTH    = 16,
    parameter int IDW      = $clog2(DEPTH),
    parameter int DATA_W   = 8,
    parameter int PREG_W   = 4,
    parameter int AREG_W   = 4,
    parameter int WB_PORTS = 2,
    parameter int RET_W    = 2
) (
    input  logic        clk,
    input  logic        rst,
    rob_multi_if.slave  bus
);
    localparam int CW = IDW + 1;

    logic [DEPTH-1:0]  valid_q, valid_d, ready_q, ready_d;
    logic [DEPTH-1:0]  br_q, br_d, misp_q, misp_d, halt_fl_q, halt_fl_d, nt_q, nt_d;
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [DATA_W-1:0] value_d [DEPTH];
    logic [PREG_W-1:0] preg_q  [DEPTH];
    logic [PREG_W-1:0] preg_d  [DEPTH];
    logic [AREG_W-1:0] areg_q  [DEPTH];
    logic [AREG_W-1:0] areg_d  [DEPTH];
    logic [IDW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              halted_q, halted_d;

    logic [WB_PORTS-1:0]        prf_valid_q, prf_valid_d;
    logic [WB_PORTS*PREG_W-1:0] prf_id_q, prf_id_d;
    logic [WB_PORTS*DATA_W-1:0] prf_value_q, prf_value_d;
    logic [RET_W-1:0]           retire_valid_q, retire_valid_d;
    logic [RET_W*AREG_W-1:0]    retire_areg_q, retire_areg_d;
    logic [RET_W*PREG_W-1:0]    retire_preg_q, retire_preg_d;
    logic                       branch_valid_q, branch_valid_d;
    logic                       branch_nt_q, branch_nt_d;
    logic [DATA_W-1:0]          new_pc_q, new_pc_d;

    logic              alloc_ready, alloc_fire;
    logic [DEPTH-1:0]  commit_mask;
    logic [CW-1:0]     commit_n;
    logic              scan_stop, flush, halt_hit;
    logic [IDW-1:0]    slot;
    logic [IDW-1:0]    wid [WB_PORTS];
    logic [7:0]        wfl [WB_PORTS];
    logic [WB_PORTS-1:0] wb_acc;
    logic              unused_flag_bits;

    assign alloc_ready = (count_q != CW'(DEPTH)) && !halted_q;
    assign alloc_fire  = bus.alloc_valid && alloc_ready;

    // Unpack writeback ports; a port loses to any lower port aimed at the same entry.
    always_comb begin
        wb_acc = '0;
        unused_flag_bits = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            wid[p] = bus.wb_id[p*IDW +: IDW];
            wfl[p] = bus.wb_flags[p*8 +: 8];
            unused_flag_bits = unused_flag_bits ^ (^{wfl[p][3:2], wfl[p][7:6]});
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_acc[p] = bus.wb_valid[p] && valid_q[wid[p]];
            for (int o = 0; o < p; o++) begin
                if (bus.wb_valid[o] && (wid[o] == wid[p])) begin
                    wb_acc[p] = 1'b0;
                end
            end
        end
    end

    // Commit scan from head; a branch or halt entry closes the group after committing.
    always_comb begin
        commit_mask    = '0;
        commit_n       = '0;
        scan_stop      = halted_q;
        flush          = 1'b0;
        halt_hit       = 1'b0;
        slot           = '0;
        retire_valid_d = '0;
        retire_areg_d  = '0;
        retire_preg_d  = '0;
        branch_valid_d = 1'b0;
        branch_nt_d    = 1'b0;
        new_pc_d       = '0;
        for (int k = 0; k < RET_W; k++) begin
            slot = head_q + IDW'(k);
            if (!scan_stop && valid_q[slot] && ready_q[slot]) begin
                commit_mask[slot] = 1'b1;
                commit_n = commit_n + CW'(1);
                if (br_q[slot]) begin
                    branch_valid_d = 1'b1;
                    branch_nt_d    = nt_q[slot];
                    new_pc_d       = value_q[slot];
                    flush          = misp_q[slot];
                end else begin
                    retire_valid_d[k] = 1'b1;
                    retire_areg_d[k*AREG_W +: AREG_W] = areg_q[slot];
                    retire_preg_d[k*PREG_W +: PREG_W] = preg_q[slot];
                end
                if (halt_fl_q[slot]) begin
                    halt_hit = 1'b1;
                end
                if (br_q[slot] || halt_fl_q[slot]) begin
                    scan_stop = 1'b1;
                end
            end else begin
                scan_stop = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d     = valid_q;
        ready_d     = ready_q;
        br_d        = br_q;
        misp_d      = misp_q;
        halt_fl_d   = halt_fl_q;
        nt_d        = nt_q;
        value_d     = value_q;
        preg_d      = preg_q;
        areg_d      = areg_q;
        halted_d    = halted_q | halt_hit;
        prf_valid_d = '0;
        prf_id_d    = '0;
        prf_value_d = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_acc[p]) begin
                ready_d[wid[p]]   = 1'b1;
                br_d[wid[p]]      = wfl[p][0];
                misp_d[wid[p]]    = wfl[p][1];
                halt_fl_d[wid[p]] = wfl[p][4];
                nt_d[wid[p]]      = wfl[p][5];
                value_d[wid[p]]   = bus.wb_value[p*DATA_W +: DATA_W];
                preg_d[wid[p]]    = bus.wb_preg[p*PREG_W +: PREG_W];
                areg_d[wid[p]]    = bus.wb_areg[p*AREG_W +: AREG_W];
                if (!wfl[p][0] && !flush) begin
                    prf_valid_d[p] = 1'b1;
                    prf_id_d[p*PREG_W +: PREG_W]    = bus.wb_preg[p*PREG_W +: PREG_W];
                    prf_value_d[p*DATA_W +: DATA_W] = bus.wb_value[p*DATA_W +: DATA_W];
                end
            end
        end
        valid_d = valid_d & ~commit_mask;
        ready_d = ready_d & ~commit_mask;
        head_d  = head_q + IDW'(commit_n);
        tail_d  = tail_q;
        count_d = count_q;
        // A mispredict empties everything younger, including this cycle's dispatch.
        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            tail_d  = head_d;
            count_d = '0;
        end else begin
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d = tail_q + IDW'(1);
            end
            count_d = count_q + CW'(alloc_fire) - commit_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            ready_q        <= '0;
            br_q           <= '0;
            misp_q         <= '0;
            halt_fl_q      <= '0;
            nt_q           <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            halted_q       <= 1'b0;
            prf_valid_q    <= '0;
            prf_id_q       <= '0;
            prf_value_q    <= '0;
            retire_valid_q <= '0;
            retire_areg_q  <= '0;
            retire_preg_q  <= '0;
            branch_valid_q <= 1'b0;
            branch_nt_q    <= 1'b0;
            new_pc_q       <= '0;
        end else begin
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            br_q           <= br_d;
            misp_q         <= misp_d;
            halt_fl_q      <= halt_fl_d;
            nt_q           <= nt_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            halted_q       <= halted_d;
            prf_valid_q    <= prf_valid_d;
            prf_id_q       <= prf_id_d;
            prf_value_q    <= prf_value_d;
            retire_valid_q <= retire_valid_d;
            retire_areg_q  <= retire_areg_d;
            retire_preg_q  <= retire_preg_d;
            branch_valid_q <= branch_valid_d;
            branch_nt_q    <= branch_nt_d;
            new_pc_q       <= new_pc_d;
        end
    end

    // Payload is qualified by valid/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        value_q <= value_d;
        preg_q  <= preg_d;
        areg_q  <= areg_d;
    end

    assign bus.alloc_ready      = alloc_ready;
    assign bus.alloc_id         = tail_q;
    assign bus.prf_valid        = prf_valid_q;
    assign bus.prf_id           = prf_id_q;
    assign bus.prf_value        = prf_value_q;
    assign bus.retire_valid     = retire_valid_q;
    assign bus.retire_areg      = retire_areg_q;
    assign bus.retire_preg      = retire_preg_q;
    assign bus.branch_valid     = branch_valid_q;
    assign bus.branch_not_taken = branch_nt_q;
    assign bus.new_pc           = new_pc_q;
    assign bus.halted           = halted_q;
    assign bus.count            = count_q;
endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios plus random traffic, checked against a queue-based model of the buffer.
module tb_rob_multi;
    localparam int DEPTH = 16;
    localparam int RET_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rob_multi_if bus();
    rob_multi dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit [3:0] id;
        bit       rdy;
        bit [7:0] fl;
        bit [7:0] val;
        bit [3:0] preg;
        bit [3:0] areg;
    } ent_t;

    ent_t q[$];
    int   m_head;
    bit   m_halted;
    int   checks = 0;
    int   errors = 0;

    bit       n_av;
    bit       n_wv   [2];
    bit [3:0] n_wid  [2];
    bit [7:0] n_fl   [2];
    bit [7:0] n_val  [2];
    bit [3:0] n_preg [2];
    bit [3:0] n_areg [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        n_av = 1'b0;
        for (int p = 0; p < 2; p++) begin
            n_wv[p] = 1'b0; n_wid[p] = '0; n_fl[p] = '0;
            n_val[p] = '0; n_preg[p] = '0; n_areg[p] = '0;
        end
    endtask

    task automatic set_wb(input int p, input bit [3:0] id, input bit [7:0] fl, input bit [7:0] val);
        n_wv[p] = 1'b1; n_wid[p] = id; n_fl[p] = fl; n_val[p] = val;
        n_preg[p] = 4'($urandom); n_areg[p] = 4'($urandom);
    endtask

    task automatic drive();
        bus.alloc_valid = n_av;
        for (int p = 0; p < 2; p++) begin
            bus.wb_valid[p]        = n_wv[p];
            bus.wb_id[p*4 +: 4]    = n_wid[p];
            bus.wb_flags[p*8 +: 8] = n_fl[p];
            bus.wb_value[p*8 +: 8] = n_val[p];
            bus.wb_preg[p*4 +: 4]  = n_preg[p];
            bus.wb_areg[p*4 +: 4]  = n_areg[p];
        end
    endtask

    function automatic int find(input bit [3:0] id);
        foreach (q[i]) if (q[i].id == id) return i;
        return -1;
    endfunction

    // One clock: check combinational state, predict registered outputs, then advance the model.
    task automatic cycle();
        int n, tail;
        int pos [2];
        bit stop, flush, hset, do_alloc;
        bit acc [2];
        bit [1:0] e_pv, e_rv;
        bit [3:0] e_pid [2];
        bit [7:0] e_pval [2];
        bit [3:0] e_ra [2];
        bit [3:0] e_rp [2];
        bit e_br, e_nt;
        bit [7:0] e_pc;
        @(negedge clk);
        drive();
        #1;
        tail = (m_head + q.size()) % DEPTH;
        do_alloc = n_av && (q.size() < DEPTH) && !m_halted;
        chk("alloc_ready", 32'(bus.alloc_ready), 32'((q.size() < DEPTH) && !m_halted));
        chk("alloc_id", 32'(bus.alloc_id), 32'(tail));
        chk("count", 32'(bus.count), 32'(q.size()));

        e_pv = '0; e_rv = '0; e_br = 0; e_nt = 0; e_pc = '0;
        n = 0; stop = m_halted; flush = 0; hset = 0;
        for (int k = 0; k < RET_W; k++) begin
            e_ra[k] = '0; e_rp[k] = '0;
            if (stop || k >= q.size()) stop = 1;
            else if (!q[k].rdy) stop = 1;
            else begin
                n++;
                if (q[k].fl[0]) begin
                    e_br = 1; e_pc = q[k].val; e_nt = q[k].fl[5]; flush = q[k].fl[1];
                end else begin
                    e_rv[k] = 1; e_ra[k] = q[k].areg; e_rp[k] = q[k].preg;
                end
                if (q[k].fl[4]) hset = 1;
                if (q[k].fl[0] || q[k].fl[4]) stop = 1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            acc[p] = 0; e_pid[p] = '0; e_pval[p] = '0;
            pos[p] = find(n_wid[p]);
            if (n_wv[p] && pos[p] >= 0 && !(p == 1 && n_wv[0] && n_wid[0] == n_wid[1])) begin
                acc[p] = 1;
                if (!n_fl[p][0] && !flush) begin
                    e_pv[p] = 1; e_pid[p] = n_preg[p]; e_pval[p] = n_val[p];
                end
            end
        end

        @(posedge clk);
        #1;
        chk("prf_valid", 32'(bus.prf_valid), 32'(e_pv));
        for (int p = 0; p < 2; p++) if (e_pv[p]) begin
            chk($sformatf("prf_id[%0d]", p), 32'(bus.prf_id[p*4 +: 4]), 32'(e_pid[p]));
            chk($sformatf("prf_value[%0d]", p), 32'(bus.prf_value[p*8 +: 8]), 32'(e_pval[p]));
        end
        chk("retire_valid", 32'(bus.retire_valid), 32'(e_rv));
        for (int k = 0; k < RET_W; k++) if (e_rv[k]) begin
            chk($sformatf("retire_areg[%0d]", k), 32'(bus.retire_areg[k*4 +: 4]), 32'(e_ra[k]));
            chk($sformatf("retire_preg[%0d]", k), 32'(bus.retire_preg[k*4 +: 4]), 32'(e_rp[k]));
        end
        chk("branch_valid", 32'(bus.branch_valid), 32'(e_br));
        if (e_br) begin
            chk("new_pc", 32'(bus.new_pc), 32'(e_pc));
            chk("branch_not_taken", 32'(bus.branch_not_taken), 32'(e_nt));
        end

        for (int p = 0; p < 2; p++) if (acc[p]) begin
            q[pos[p]].rdy = 1; q[pos[p]].fl = n_fl[p]; q[pos[p]].val = n_val[p];
            q[pos[p]].preg = n_preg[p]; q[pos[p]].areg = n_areg[p];
        end
        repeat (n) void'(q.pop_front());
        m_head = (m_head + n) % DEPTH;
        if (flush) q.delete();
        else if (do_alloc) q.push_back('{id: 4'(tail), rdy: 1'b0, fl: 8'h0, val: 8'h0, preg: 4'h0, areg: 4'h0});
        if (hset) m_halted = 1;
        chk("halted", 32'(bus.halted), 32'(m_halted));
    endtask

    task automatic do_reset(input bit busy);
        @(negedge clk);
        rst = 1'b1;
        clear_in();
        if (busy) begin
            n_av = 1'b1;
            set_wb(0, 4'($urandom), 8'h00, 8'($urandom));
            set_wb(1, 4'($urandom), 8'h01, 8'($urandom));
        end
        drive();
        @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_alloc_id", 32'(bus.alloc_id), 32'd0);
        chk("rst_prf_valid", 32'(bus.prf_valid), 32'd0);
        chk("rst_prf_value", 32'(bus.prf_value), 32'd0);
        chk("rst_retire_valid", 32'(bus.retire_valid), 32'd0);
        chk("rst_retire_areg", 32'(bus.retire_areg), 32'd0);
        chk("rst_branch_valid", 32'(bus.branch_valid), 32'd0);
        chk("rst_new_pc", 32'(bus.new_pc), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        rst = 1'b0;
        q.delete(); m_head = 0; m_halted = 0;
        clear_in();
    endtask

    task automatic allocs(input int cnt);
        repeat (cnt) begin clear_in(); n_av = 1'b1; cycle(); end
    endtask

    int r;

    initial begin
        clear_in();
        drive();

        // In-order commit of out-of-order writebacks.
        do_reset(0);
        allocs(3);
        clear_in(); set_wb(0, 4'd1, 8'h00, 8'hA1); cycle();
        clear_in(); set_wb(0, 4'd0, 8'h00, 8'hA0); cycle();
        clear_in(); cycle();
        chk("s1_pair_retire", 32'(bus.retire_valid), 32'h3);
        clear_in(); set_wb(1, 4'd2, 8'h00, 8'hA2); cycle();
        clear_in(); cycle();
        chk("s1_last_retire", 32'(bus.retire_valid), 32'h1);

        // Full buffer, ignored alloc, wrap of the tail, alloc alongside commit.
        do_reset(0);
        allocs(17);
        chk("s2_full_count", 32'(bus.count), 32'd16);
        chk("s2_full_ready", 32'(bus.alloc_ready), 32'd0);
        chk("s2_wrap_id", 32'(bus.alloc_id), 32'd0);
        clear_in(); n_av = 1; set_wb(0, 4'd0, 8'h00, 8'h5A); cycle();
        clear_in(); n_av = 1; set_wb(0, 4'd1, 8'h00, 8'h5B); cycle();
        clear_in(); n_av = 1; cycle();
        chk("s2_net_count", 32'(bus.count), 32'd15);
        chk("s2_tail_after_wrap", 32'(bus.alloc_id), 32'd1);

        // Two ports hitting the same entry.
        do_reset(0);
        allocs(6);
        clear_in(); set_wb(0, 4'd5, 8'h00, 8'h11); set_wb(1, 4'd5, 8'h00, 8'h22); cycle();
        chk("s3_prf_valid", 32'(bus.prf_valid), 32'h1);
        chk("s3_prf_value", 32'(bus.prf_value[7:0]), 32'h11);
        clear_in(); set_wb(0, 4'd0, 8'h00, 8'h30); set_wb(1, 4'd1, 8'h00, 8'h31); cycle();
        clear_in(); set_wb(0, 4'd2, 8'h00, 8'h32); set_wb(1, 4'd3, 8'h00, 8'h33); cycle();
        clear_in(); set_wb(0, 4'd4, 8'h00, 8'h34); cycle();
        repeat (3) begin clear_in(); cycle(); end

        // Mispredicted branch flushes younger entries and this cycle's traffic.
        do_reset(0);
        allocs(8);
        clear_in(); set_wb(0, 4'd0, 8'h00, 8'h70); set_wb(1, 4'd1, 8'h00, 8'h71); cycle();
        clear_in(); set_wb(0, 4'd2, 8'h00, 8'h72); set_wb(1, 4'd3, 8'h23, 8'h40); cycle();
        clear_in(); n_av = 1; set_wb(0, 4'd6, 8'h00, 8'h76); cycle();
        chk("s4_branch_valid", 32'(bus.branch_valid), 32'd1);
        chk("s4_new_pc", 32'(bus.new_pc), 32'h40);
        chk("s4_not_taken", 32'(bus.branch_not_taken), 32'd1);
        chk("s4_count", 32'(bus.count), 32'd0);
        chk("s4_tail", 32'(bus.alloc_id), 32'd4);
        chk("s4_wb_dropped", 32'(bus.prf_valid), 32'd0);
        clear_in(); cycle();

        // Halt is sticky; writebacks still reach the PRF.
        do_reset(0);
        allocs(4);
        clear_in(); set_wb(0, 4'd0, 8'h00, 8'h80); set_wb(1, 4'd1, 8'h00, 8'h81); cycle();
        clear_in(); set_wb(0, 4'd2, 8'h10, 8'h82); cycle();
        clear_in(); cycle();
        chk("s5_halted", 32'(bus.halted), 32'd1);
        repeat (3) begin clear_in(); n_av = 1; set_wb(1, 4'd3, 8'h00, 8'($urandom)); cycle(); end
        chk("s5_alloc_blocked", 32'(bus.alloc_ready), 32'd0);

        // Reset with work in flight.
        do_reset(0);
        allocs(8);
        clear_in(); set_wb(0, 4'd0, 8'h00, 8'h90); set_wb(1, 4'd1, 8'h00, 8'h91); cycle();
        do_reset(1);
        repeat (3) begin clear_in(); cycle(); end

        // Random traffic against the model.
        do_reset(0);
        for (int c = 0; c < 600; c++) begin
            clear_in();
            n_av = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    n_wv[p] = 1'b1;
                    if (q.size() > 0 && $urandom_range(0, 7) != 0)
                        n_wid[p] = q[$urandom_range(0, q.size() - 1)].id;
                    else
                        n_wid[p] = 4'($urandom);
                    r = $urandom_range(0, 99);
                    n_fl[p] = 8'($urandom) & 8'hCC;
                    if (r < 12) n_fl[p] = n_fl[p] | 8'h01 | {2'b0, r[0], 3'b0, r[1], 1'b0};
                    else if (r == 12) n_fl[p] = n_fl[p] | 8'h10;
                    n_val[p] = 8'($urandom); n_preg[p] = 4'($urandom); n_areg[p] = 4'($urandom);
                end
            end
            cycle();
            if (c % 100 == 99) do_reset(c % 200 == 199);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
